prog_loader: RTL

Byte-wide program loader for the programmable FSM controller. It accepts a program image from a host over a valid/ready byte interface and buffers the whole image. It then streams the image into the controller's instruction/constant memory as one unbroken burst on `prog_enable`/`prog_data`. Because the burst is contiguous, the controller is never released from program-reset with a partially written memory.

---
 rtl/prog_loader_pkg.sv | 36 +++
 rtl/prog_loader_if.sv | 19 +
 rtl/prog_shifter.sv | 90 +++++++++
 rtl/prog_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader: loader state encoding, the byte
// width of the host channel, image sizing helpers and the checksum fold.
// The CHECK state only exists when PROG_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
package prog_loader_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK = 2'd2,
`endif
      ST_SHIFT = 2'd3
   } state_e;

   // Number of whole bytes needed to carry an image of the given bit length.
   function automatic int nbytes(input int bits);
      return (bits + BYTE_W - 1) / BYTE_W;
   endfunction

   // Width of a counter that must hold the values 0..bits inclusive.
   function automatic int bit_cnt_w(input int bits);
      return $clog2(bits + 1);
   endfunction

   // One step of the running image checksum (bytewise XOR).
   function automatic logic [BYTE_W-1:0] xor_acc(input logic [BYTE_W-1:0] acc,
                                                 input logic [BYTE_W-1:0] data);
      return acc ^ data;
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
// Host byte channel into the program loader (valid/ready, one byte per beat).
//   in_valid : host -> loader, byte present
//   in_data  : host -> loader, byte value
//   in_ready : loader -> host, byte accepted when both valid and ready are high
// Modports: master (host side), slave (loader side).
// -----------------------------------------------------------------------------
interface prog_loader_if;
   import prog_loader_pkg::*;

   logic              in_valid;
   logic [BYTE_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/prog_shifter.sv
// -----------------------------------------------------------------------------
// prog_shifter
// Holds the byte-addressed program image and streams it out LSB-first as one
// contiguous burst of PROG_BITS cycles once 'go' is pulsed.
// Ports:
//   clock, rst_n       : clock and synchronous active-low reset
//   wr_en/wr_idx/wr_data : byte write port, byte i lands on bits [8i+7:8i]
//   go                 : start the burst (may coincide with the final write)
//   prog_enable        : high on every cycle carrying a program bit
//   prog_data          : current program bit
//   last               : the burst ends at the coming edge
// -----------------------------------------------------------------------------
module prog_shifter
   import prog_loader_pkg::*;
#(
   parameter int PROG_BITS = 112,
   parameter int IDX_W     = 4
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [BYTE_W-1:0] wr_data,
   input  logic              go,
   output logic              prog_enable,
   output logic              prog_data,
   output logic              last
);

   localparam int NBYTES = nbytes(PROG_BITS);
   localparam int IMG_W  = NBYTES * BYTE_W;
   localparam int CNT_W  = bit_cnt_w(PROG_BITS);

   logic [IMG_W-1:0] img_r;
   logic [IMG_W-1:0] img_wr_s;
   logic [CNT_W-1:0] cnt_r;
   logic             en_r;
   logic             data_r;

   // Image with the current byte write applied; lets the burst start on the
   // same edge that stores the final byte.
   always_comb begin
      img_wr_s = img_r;
      for (int i = 0; i < NBYTES; i++) begin
         if (wr_en && (wr_idx == IDX_W'(i))) begin
            img_wr_s[i*BYTE_W +: BYTE_W] = wr_data;
         end else begin
            img_wr_s[i*BYTE_W +: BYTE_W] = img_r[i*BYTE_W +: BYTE_W];
         end
      end
   end

   // cnt_r counts bits already placed on prog_data; reaching PROG_BITS ends it.
   assign last = en_r && (cnt_r == CNT_W'(PROG_BITS));

   // Image storage, bit emitter and burst counter. The image shifts right so
   // bit 0 is always the next bit; pad bits above PROG_BITS never reach it.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         img_r  <= {IMG_W{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
         en_r   <= 1'b0;
         data_r <= 1'b0;
      end else if (go) begin
         data_r <= img_wr_s[0];
         img_r  <= {1'b0, img_wr_s[IMG_W-1:1]};
         cnt_r  <= CNT_W'(1);
         en_r   <= 1'b1;
      end else if (last) begin
         data_r <= 1'b0;
         img_r  <= img_r;
         cnt_r  <= {CNT_W{1'b0}};
         en_r   <= 1'b0;
      end else if (en_r) begin
         data_r <= img_r[0];
         img_r  <= {1'b0, img_r[IMG_W-1:1]};
         cnt_r  <= cnt_r + CNT_W'(1);
         en_r   <= 1'b1;
      end else begin
         data_r <= 1'b0;
         img_r  <= img_wr_s;
         cnt_r  <= cnt_r;
         en_r   <= 1'b0;
      end
   end

   assign prog_enable = en_r;
   assign prog_data   = data_r;

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Buffers a complete program image from the host byte channel, then streams
// it to the controller as one unbroken burst so the controller never leaves
// program-reset with a half-written memory.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN -- an extra trailing byte
// carries the XOR of all image bytes; a mismatch raises 'error' and drops the
// image without any burst.
// Ports:
//   clock, rst_n : clock and synchronous active-low reset
//   start        : begin a load (IDLE only)
//   host         : byte channel (in_valid, in_data, in_ready)
//   prog_enable  : high exactly on cycles carrying a program bit
//   prog_data    : program bit, LSB of byte 0 first
//   busy         : high outside IDLE
//   done         : one-cycle pulse after the last bit
//   error        : sticky checksum failure, cleared by an accepted start
// -----------------------------------------------------------------------------
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int PROG_BITS = 112
) (
   input  logic            clock,
   input  logic            rst_n,
   input  logic            start,
   prog_loader_if.slave    host,
   output logic            prog_enable,
   output logic            prog_data,
   output logic            busy,
   output logic            done,
   output logic            error
);

   localparam int NBYTES  = nbytes(PROG_BITS);
`ifdef PROG_LOADER_CHECKSUM_EN
   localparam int NACCEPT = NBYTES + 1;
`else
   localparam int NACCEPT = NBYTES;
`endif
   localparam int BCNT_W  = $clog2(NACCEPT + 1);

   state_e            state_r;
   state_e            state_nxt_s;
   logic [BCNT_W-1:0] byte_cnt_r;
   logic              in_ready_r;
   logic              busy_r;
   logic              done_r;
   logic              accept_s;
   logic              wr_en_s;
   logic              go_s;
   logic              start_ok_s;
   logic              shift_last_s;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] xor_r;
   logic [BYTE_W-1:0] cksum_r;
   logic              error_r;
   logic              ck_fail_s;
`endif

   assign accept_s   = host.in_valid && in_ready_r;
   assign start_ok_s = (state_r == ST_IDLE) && start;
   // Only image bytes reach the image store; a trailing checksum byte does not.
   assign wr_en_s    = accept_s && (byte_cnt_r < BCNT_W'(NBYTES));

   // State register.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and the burst launch strobe.
   always_comb begin
      state_nxt_s = state_r;
      go_s        = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      ck_fail_s   = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (accept_s && (byte_cnt_r == BCNT_W'(NACCEPT - 1))) begin
`ifdef PROG_LOADER_CHECKSUM_EN
               state_nxt_s = ST_CHECK;
`else
               state_nxt_s = ST_SHIFT;
               go_s        = 1'b1;
`endif
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (cksum_r == xor_r) begin
               state_nxt_s = ST_SHIFT;
               go_s        = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
               ck_fail_s   = 1'b1;
            end
         end
`endif
         ST_SHIFT: begin
            if (shift_last_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Byte counter and registered status outputs.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         byte_cnt_r <= {BCNT_W{1'b0}};
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         in_ready_r <= (state_nxt_s == ST_LOAD);
         busy_r     <= (state_nxt_s != ST_IDLE);
         done_r     <= (state_r == ST_SHIFT) && shift_last_s;
         if (start_ok_s) begin
            byte_cnt_r <= {BCNT_W{1'b0}};
         end else if (accept_s) begin
            byte_cnt_r <= byte_cnt_r + BCNT_W'(1);
         end else begin
            byte_cnt_r <= byte_cnt_r;
         end
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   // Running XOR of image bytes, captured checksum byte and sticky error.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         xor_r   <= {BYTE_W{1'b0}};
         cksum_r <= {BYTE_W{1'b0}};
         error_r <= 1'b0;
      end else begin
         if (start_ok_s) begin
            xor_r <= {BYTE_W{1'b0}};
         end else if (wr_en_s) begin
            xor_r <= xor_acc(xor_r, host.in_data);
         end else begin
            xor_r <= xor_r;
         end
         if (accept_s && (byte_cnt_r == BCNT_W'(NBYTES))) begin
            cksum_r <= host.in_data;
         end else begin
            cksum_r <= cksum_r;
         end
         if (start_ok_s) begin
            error_r <= 1'b0;
         end else if (ck_fail_s) begin
            error_r <= 1'b1;
         end else begin
            error_r <= error_r;
         end
      end
   end

   assign error = error_r;
`else
   assign error = 1'b0;
`endif

   prog_shifter #(
      .PROG_BITS (PROG_BITS),
      .IDX_W     (BCNT_W)
   ) u_shifter (
      .clock       (clock),
      .rst_n       (rst_n),
      .wr_en       (wr_en_s),
      .wr_idx      (byte_cnt_r),
      .wr_data     (host.in_data),
      .go          (go_s),
      .prog_enable (prog_enable),
      .prog_data   (prog_data),
      .last        (shift_last_s)
   );

   assign host.in_ready = in_ready_r;
   assign busy          = busy_r;
   assign done          = done_r;

endmodule
